pc_fetch_unit: RTL and testbench

- Holds the program counter and runs a two-phase fetch/execute sequence against the instruction cache.
- Drives PC+4 and the branch target into the next-PC select mux, and consumes that mux's output (PC_NEXT) as the next PC.
- Latches the fetched instruction for the datapath.
- Stalls on instruction-cache and data-cache busywait.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/branch_target_adder.sv | 23 ++
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 tb/tb_pc_fetch_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-unit definitions: PC defaults, fetch FSM encodings, instruction reset value.
package cpu_pkg;

    localparam int          PC_WIDTH_DEF     = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] INSTR_RESET      = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/branch_target_adder.sv
// Combinational PC+4 and PC+4+(sext(OFFSET)<<2); both wrap modulo 2^PC_WIDTH.
module branch_target_adder #(
    parameter int PC_WIDTH     = 32,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0]     PC,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    output logic [PC_WIDTH-1:0]     PC_PLUS4,
    output logic [PC_WIDTH-1:0]     BRANCH_TARGET
);

    localparam logic [PC_WIDTH-1:0] FOUR = PC_WIDTH'(4);

    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] offset_bytes;

    // Word offset -> byte offset; sign extension happens before the shift.
    assign offset_ext    = {{(PC_WIDTH-OFFSET_WIDTH){OFFSET[OFFSET_WIDTH-1]}}, OFFSET};
    assign offset_bytes  = offset_ext << 2;
    assign PC_PLUS4      = PC + FOUR;
    assign BRANCH_TARGET = PC_PLUS4 + offset_bytes;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and BOOT/FETCH/EXEC sequencer against the instruction cache.
// Optional PC_ALIGN_CHECK_EN: force-align loaded PCs and raise a sticky MISALIGN flag.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                 PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
    parameter int                 OFFSET_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [PC_WIDTH-1:0]     PC_NEXT,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    input  logic [31:0]             IMEM_INSTR,
    input  logic                    IMEM_BUSYWAIT,
    input  logic                    DMEM_BUSYWAIT,
    output logic                    IMEM_READ,
    output logic [PC_WIDTH-1:0]     IMEM_ADDR,
    output logic [PC_WIDTH-1:0]     PC,
    output logic [PC_WIDTH-1:0]     PC_PLUS4,
    output logic [PC_WIDTH-1:0]     BRANCH_TARGET,
    output logic [31:0]             INSTR,
    output logic                    INSTR_VALID
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                    MISALIGN
`endif
);

    fetch_state_t        state, state_next;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_load;
    logic [31:0]         instr_q;
    logic                valid_q;
    logic                fetch_done;
    logic                exec_done;

    assign fetch_done = (state == FETCH) && !IMEM_BUSYWAIT;
    assign exec_done  = (state == EXEC)  && !DMEM_BUSYWAIT;

    always_ff @(posedge CLK) begin
        if (!RESET) state <= BOOT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        IMEM_READ  = 1'b0;
        unique case (state)
            BOOT:  state_next = FETCH;
            FETCH: begin
                IMEM_READ = 1'b1;
                if (!IMEM_BUSYWAIT) state_next = EXEC;
            end
            EXEC:  if (!DMEM_BUSYWAIT) state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;
    logic next_misaligned;

    assign next_misaligned = |PC_NEXT[1:0];
    assign pc_load         = {PC_NEXT[PC_WIDTH-1:2], 2'b00};
    assign MISALIGN        = misalign_q;

    always_ff @(posedge CLK) begin
        if (!RESET)                           misalign_q <= 1'b0;
        else if (exec_done && next_misaligned) misalign_q <= 1'b1;
    end
`else
    assign pc_load = PC_NEXT;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc_q    <= RESET_VECTOR;
            instr_q <= INSTR_RESET;
            valid_q <= 1'b0;
        end else begin
            if (fetch_done) begin
                instr_q <= IMEM_INSTR;
                valid_q <= 1'b1;
            end
            if (exec_done) begin
                pc_q    <= pc_load;
                valid_q <= 1'b0;
            end
        end
    end

    assign PC          = pc_q;
    assign IMEM_ADDR   = pc_q;
    assign INSTR       = instr_q;
    assign INSTR_VALID = valid_q;

    branch_target_adder #(
        .PC_WIDTH     (PC_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_bta (
        .PC            (pc_q),
        .OFFSET        (OFFSET),
        .PC_PLUS4      (PC_PLUS4),
        .BRANCH_TARGET (BRANCH_TARGET)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven bench for pc_fetch_unit; each vector is one clock cycle.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] PC_NEXT = '0;
    logic [7:0]  OFFSET = '0;
    logic [31:0] IMEM_INSTR = '0;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic        DMEM_BUSYWAIT = 1'b0;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR, PC, PC_PLUS4, BRANCH_TARGET, INSTR;
    logic        INSTR_VALID;
`ifdef PC_ALIGN_CHECK_EN
    logic        MISALIGN;
`endif

    always #5 CLK = ~CLK;

    pc_fetch_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PC_NEXT       (PC_NEXT),
        .OFFSET        (OFFSET),
        .IMEM_INSTR    (IMEM_INSTR),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDR     (IMEM_ADDR),
        .PC            (PC),
        .PC_PLUS4      (PC_PLUS4),
        .BRANCH_TARGET (BRANCH_TARGET),
        .INSTR         (INSTR),
        .INSTR_VALID   (INSTR_VALID)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .MISALIGN      (MISALIGN)
`endif
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc_next;
        logic [7:0]  off;
        logic [31:0] imem;
        logic        ib;
        logic        db;
        logic        e_read;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_p4;
        logic [31:0] e_bt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic rst, logic [31:0] pc_next, logic [7:0] off,
                                logic [31:0] imem, logic ib, logic db, logic e_read,
                                logic [31:0] e_pc, logic e_valid, logic [31:0] e_instr,
                                logic [31:0] e_p4, logic [31:0] e_bt);
        vec_t v;
        v.rst = rst; v.pc_next = pc_next; v.off = off; v.imem = imem;
        v.ib = ib; v.db = db; v.e_read = e_read; v.e_pc = e_pc;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_p4 = e_p4; v.e_bt = e_bt;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic [31:0] pcn, logic [7:0] off,
                         logic [31:0] imem, logic ib, logic db);
        @(negedge CLK);
        RESET = rst; PC_NEXT = pcn; OFFSET = off;
        IMEM_INSTR = imem; IMEM_BUSYWAIT = ib; DMEM_BUSYWAIT = db;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(int idx, logic e_read, logic [31:0] e_pc, logic e_valid,
                               logic [31:0] e_instr);
        n_vec++;
        chk("imem_read",   idx, {31'b0, IMEM_READ},   {31'b0, e_read});
        chk("imem_addr",   idx, IMEM_ADDR,            e_pc);
        chk("pc",          idx, PC,                   e_pc);
        chk("instr_valid", idx, {31'b0, INSTR_VALID}, {31'b0, e_valid});
        chk("instr",       idx, INSTR,                e_instr);
    endtask

    initial begin
        // rst pc_next off imem ib db | read pc valid instr p4 bt
        vecs.push_back(mk(0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 0, 0, 4, 4));
        vecs.push_back(mk(0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 0, 0, 4, 4));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0, 0, 0, 1, 0, 0, 0, 4, 4));
        vecs.push_back(mk(1, 4, 8'h00, 32'h0000_0A01, 0, 0, 0, 0, 1, 32'h0A01, 4, 4));
        vecs.push_back(mk(1, 4, 8'h00, 32'h0, 0, 0, 1, 4, 0, 32'h0A01, 8, 8));
        vecs.push_back(mk(1, 8, 8'h00, 32'h0000_0B02, 0, 0, 0, 4, 1, 32'h0B02, 8, 8));
        vecs.push_back(mk(1, 8, 8'h00, 32'h0, 0, 0, 1, 8, 0, 32'h0B02, 12, 12));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 8, 8'hFE, 32'hFFFF_FFFF, 1, 0, 1, 8, 0, 32'h0B02, 12, 4));
        vecs.push_back(mk(1, 8, 8'h7F, 32'h0000_0C03, 0, 0, 0, 8, 1, 32'h0C03, 12, 520));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 32'hFFFF_FFFC, 8'h00, 32'h0, 1, 1, 0, 8, 1, 32'h0C03, 12, 12));
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 8'h00, 32'h0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0C03, 0, 0));
        vecs.push_back(mk(1, 12, 8'h01, 32'h0000_0D04, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h0D04, 0, 4));
        vecs.push_back(mk(1, 12, 8'h00, 32'h0, 0, 0, 1, 12, 0, 32'h0D04, 16, 16));
        vecs.push_back(mk(1, 12, 8'h00, 32'h0, 1, 0, 1, 12, 0, 32'h0D04, 16, 16));
        // Reset while the miss at PC=12 is pending.
        vecs.push_back(mk(0, 12, 8'h00, 32'h0, 1, 0, 0, 0, 0, 0, 4, 4));
        vecs.push_back(mk(1, 12, 8'h00, 32'h0, 1, 1, 1, 0, 0, 0, 4, 4));
        vecs.push_back(mk(1, 16, 8'h00, 32'h0000_0E05, 0, 1, 0, 0, 1, 32'h0E05, 4, 4));
        vecs.push_back(mk(1, 16, 8'h00, 32'h0, 0, 0, 1, 16, 0, 32'h0E05, 20, 20));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].pc_next, vecs[i].off, vecs[i].imem,
                  vecs[i].ib, vecs[i].db);
            check_state(i, vecs[i].e_read, vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_instr);
            chk("pc_plus4",      i, PC_PLUS4,      vecs[i].e_p4);
            chk("branch_target", i, BRANCH_TARGET, vecs[i].e_bt);
`ifdef PC_ALIGN_CHECK_EN
            chk("misalign",      i, {31'b0, MISALIGN}, 32'h0);
`endif
        end

        // Reset lands during a data stall in EXEC and must win.
        drive(1, 16, 8'h00, 32'h0000_0F06, 0, 0);
        check_state(100, 0, 16, 1, 32'h0F06);
        drive(0, 20, 8'h00, 32'h0, 0, 1);
        check_state(101, 0, 0, 0, 32'h0);
        drive(1, 20, 8'h00, 32'h0, 0, 1);
        check_state(102, 1, 0, 0, 32'h0);
        drive(1, 6, 8'h00, 32'h0000_1007, 0, 0);
        check_state(103, 0, 0, 1, 32'h1007);

        // Misaligned PC_NEXT: aligned and flagged with the check, verbatim without.
        drive(1, 6, 8'h00, 32'h0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
        check_state(104, 1, 4, 0, 32'h1007);
        chk("misalign_set", 104, {31'b0, MISALIGN}, 32'h1);
        drive(1, 8, 8'h00, 32'h0000_1108, 0, 0);
        drive(1, 8, 8'h00, 32'h0, 0, 0);
        check_state(105, 1, 8, 0, 32'h1108);
        chk("misalign_sticky", 105, {31'b0, MISALIGN}, 32'h1);
`else
        check_state(104, 1, 6, 0, 32'h1007);
        chk("pc_plus4_odd", 104, PC_PLUS4, 32'h0000_000A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
